axi_lite_reg_selftest: RTL and testbench

Synthesizable AXI4-Lite master that runs a write/read-back/compare sweep over a parametrised bank of slave registers and reports pass/fail with error count. It sits beside an AXI4-Lite peripheral, such as the rangefinder VGA register slave, and provides a power-on or on-demand register self-test in hardware.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_reg_selftest_xfer.sv | 111 +++++++++++
 rtl/axi_lite_reg_selftest.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_lite_reg_selftest.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the register self-test
// sequencer state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RD,
    ST_RR,
    ST_CMP,
    ST_FIN
  } selftest_state_t;

endpackage

// File: rtl/axi_lite_reg_selftest_xfer.sv
// Single AXI4-Lite write or read handshake engine for the register self-test.
// AW and W valids are launched together and each drops on its own ready;
// B/R readies are raised once the address phase of the transfer completes.
module axi_lite_reg_selftest_xfer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                i_abort,
  input  logic                i_wr_req,
  input  logic                i_rd_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_wr_busy,
  output logic                o_wr_done,
  output logic                o_b_done,
  output logic                o_rd_busy,
  output logic                o_ar_done,
  output logic                o_r_done,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic                m_rvalid,
  output logic                m_rready
);

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic              w_aw_ok;
  logic              w_w_ok;

  // A write is in flight while either valid is still up; the last valid to
  // drop always coincides with the completion cycle, so no extra flag is kept.
  assign w_aw_ok   = !r_awvalid || m_awready;
  assign w_w_ok    = !r_wvalid  || m_wready;
  assign o_wr_busy = r_awvalid || r_wvalid;
  assign o_wr_done = o_wr_busy && w_aw_ok && w_w_ok;
  assign o_b_done  = r_bready && m_bvalid;
  assign o_rd_busy = r_arvalid;
  assign o_ar_done = r_arvalid && m_arready;
  assign o_r_done  = r_rready && m_rvalid;

  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_awprot  = '0;
  assign m_arprot  = '0;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = '1;
  assign m_awvalid = r_awvalid;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

  // Channel valid/ready registers with address/data held stable until ready.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else if (i_abort) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      if (i_wr_req) begin
        r_addr    <= i_addr;
        r_wdata   <= i_wdata;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else begin
        if (r_awvalid && m_awready) r_awvalid <= 1'b0;
        if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
      end
      if (o_wr_done) r_bready <= 1'b1;
      if (o_b_done)  r_bready <= 1'b0;
      if (i_rd_req) begin
        r_addr    <= i_addr;
        r_arvalid <= 1'b1;
      end else if (o_ar_done) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (o_r_done) r_rready <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_reg_selftest.sv
// AXI4-Lite register self-test master: writes a seed-derived pattern to each
// register, reads it back, compares, and reports pass/fail with error count.
// Optional per-handshake watchdog enabled by AXI_SELFTEST_TIMEOUT_EN.
module axi_lite_reg_selftest
  import axi_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       NUM_REGS       = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned       ADDR_STRIDE    = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic                               start,
  input  logic [DATA_W-1:0]                  seed,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [$clog2(2*NUM_REGS+1)-1:0]    err_count,
  output logic [ADDR_W-1:0]                  first_err_addr,
  output logic [ADDR_W-1:0]                  m_awaddr,
  output logic [2:0]                         m_awprot,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  output logic [DATA_W-1:0]                  m_wdata,
  output logic [DATA_W/8-1:0]                m_wstrb,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  input  logic [1:0]                         m_bresp,
  input  logic                               m_bvalid,
  output logic                               m_bready,
  output logic [ADDR_W-1:0]                  m_araddr,
  output logic [2:0]                         m_arprot,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic [1:0]                         m_rresp,
  input  logic                               m_rvalid,
  output logic                               m_rready
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned ERR_W = $clog2(2*NUM_REGS+1);

  selftest_state_t   r_state;
  selftest_state_t   w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_rdata;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_pattern;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_err;
  logic              w_tmo;
  logic              w_wr_busy;
  logic              w_wr_done;
  logic              w_b_done;
  logic              w_rd_busy;
  logic              w_ar_done;
  logic              w_r_done;

  // rotl(seed, idx mod DATA_W) XOR idx; the upper half of the doubled word
  // shifted left is the rotation.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [DATA_W-1:0] s,
                                                  input logic [IDX_W-1:0]  i);
    logic [2*DATA_W-1:0] dbl;
    int unsigned         sh;
    sh  = 32'(i) % DATA_W;
    dbl = {s, s} << sh;
    return dbl[2*DATA_W-1 -: DATA_W] ^ DATA_W'(i);
  endfunction

  assign w_addr    = BASE_ADDR + ADDR_W'(r_idx) * ADDR_W'(ADDR_STRIDE);
  assign w_pattern = f_pattern(r_seed, r_idx);

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_cnt;
  assign first_err_addr = r_first_err;

`ifdef AXI_SELFTEST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  assign timeout = r_timeout;

  // Watchdog: counts cycles spent in the current state, restarting on change.
  always_ff @(posedge ACLK) begin
    if (ARESET || (w_next != r_state)) r_tmo_cnt <= '0;
    else                               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Sticky abort flag for the current sweep, cleared on an accepted start.
  always_ff @(posedge ACLK) begin
    if (ARESET)                              r_timeout <= 1'b0;
    else if (r_state == ST_IDLE && start)    r_timeout <= 1'b0;
    else if (w_tmo)                          r_timeout <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state, transfer requests and per-cycle error detection.
  always_comb begin
    w_next   = r_state;
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    w_err    = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_WR;
      ST_WR: begin
        w_wr_req = !w_wr_busy;
        if (w_wr_done) w_next = ST_WB;
      end
      ST_WB: if (w_b_done) begin
        w_next = ST_RD;
        w_err  = (m_bresp != RESP_OKAY);
      end
      ST_RD: begin
        w_rd_req = !w_rd_busy;
        if (w_ar_done) w_next = ST_RR;
      end
      ST_RR: if (w_r_done) begin
        w_next = ST_CMP;
        w_err  = (m_rresp != RESP_OKAY);
      end
      ST_CMP: begin
        w_err  = (r_rdata != w_pattern);
        w_next = (r_idx == IDX_W'(NUM_REGS-1)) ? ST_FIN : ST_WR;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
`ifdef AXI_SELFTEST_TIMEOUT_EN
    // A handshake completing on the limit cycle wins over the abort so that
    // one register never logs both a response error and a timeout.
    if ((r_state inside {ST_WR, ST_WB, ST_RD, ST_RR}) && (w_next == r_state) &&
        (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1))) begin
      w_tmo    = 1'b1;
      w_err    = 1'b1;
      w_wr_req = 1'b0;
      w_rd_req = 1'b0;
      w_next   = ST_FIN;
    end
`endif
  end

  // Sweep bookkeeping: seed/index, read capture, error tally and status.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_seed      <= '0;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE && start) begin
        r_seed      <= seed;
        r_idx       <= '0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
        r_busy      <= 1'b1;
        r_pass      <= 1'b0;
      end
      if (w_err) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
        if (r_err_cnt == '0) r_first_err <= w_addr;
      end
      if (r_state == ST_RR && w_r_done)   r_rdata <= m_rdata;
      if (r_state == ST_CMP && w_next == ST_WR) r_idx <= r_idx + IDX_W'(1);
      if (r_state == ST_FIN) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= (r_err_cnt == '0) && !timeout;
      end
    end
  end

  axi_lite_reg_selftest_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .i_abort   (w_tmo),
    .i_wr_req  (w_wr_req),
    .i_rd_req  (w_rd_req),
    .i_addr    (w_addr),
    .i_wdata   (w_pattern),
    .o_wr_busy (w_wr_busy),
    .o_wr_done (w_wr_done),
    .o_b_done  (w_b_done),
    .o_rd_busy (w_rd_busy),
    .o_ar_done (w_ar_done),
    .o_r_done  (w_r_done),
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// Directed bench for axi_lite_reg_selftest with a small behavioural AXI4-Lite
// memory slave that can skew readies, inject response errors and corrupt data.
`timescale 1ns/1ps
module tb_axi_lite_reg_selftest;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [3:0]  err_count;
  logic [31:0] first_err_addr;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // slave knobs (written only by the stimulus process)
  int unsigned aw_dly, w_dly;
  logic        berr_en, rerr_en, ar_stuck_en;
  logic [31:0] berr_addr, rerr_addr, ar_stuck_addr;
  logic [31:0] rmask [0:15];

  // slave state
  logic [31:0] mem [0:15];
  logic        got_aw, got_w;
  logic [31:0] aw_q, w_q, last_waddr;
  int unsigned aw_wait, w_wait;
  int unsigned aw_hs = 0, w_hs = 0, stab_viol = 0, done_cnt = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  logic        s_a_ok, s_w_ok;
  logic [31:0] s_waddr, s_wdat;

  always #5 ACLK = ~ACLK;

  axi_lite_reg_selftest #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(4), .BASE_ADDR(32'h0),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  assign m_awready = m_awvalid && (aw_wait >= aw_dly);
  assign m_wready  = m_wvalid && (w_wait >= w_dly);
  assign m_arready = m_arvalid && !(ar_stuck_en && m_araddr == ar_stuck_addr);
  assign s_a_ok    = got_aw || (m_awvalid && m_awready);
  assign s_w_ok    = got_w || (m_wvalid && m_wready);
  assign s_waddr   = got_aw ? aw_q : m_awaddr;
  assign s_wdat    = got_w ? w_q : m_wdata;

  always @(posedge ACLK) begin
    if (ARESET || !m_awvalid || m_awready) aw_wait <= 0; else aw_wait <= aw_wait + 1;
    if (ARESET || !m_wvalid || m_wready)   w_wait  <= 0; else w_wait  <= w_wait + 1;
  end

  always @(posedge ACLK) begin
    if (ARESET) begin
      got_aw <= 1'b0; got_w <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_bresp <= 2'b00; m_rresp <= 2'b00; m_rdata <= '0;
    end else begin
      if (m_awvalid && m_awready) begin got_aw <= 1'b1; aw_q <= m_awaddr; aw_hs <= aw_hs + 1; end
      if (m_wvalid && m_wready)   begin got_w  <= 1'b1; w_q  <= m_wdata;  w_hs  <= w_hs + 1;  end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (s_a_ok && s_w_ok && !m_bvalid) begin
        mem[s_waddr[5:2]] <= s_wdat;
        last_waddr <= s_waddr;
        got_aw <= 1'b0; got_w <= 1'b0;
        m_bvalid <= 1'b1;
        m_bresp <= (berr_en && s_waddr == berr_addr) ? 2'b10 : 2'b00;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr[5:2]] ^ rmask[m_araddr[5:2]];
        m_rresp  <= (rerr_en && m_araddr == rerr_addr) ? 2'b10 : 2'b00;
      end
    end
  end

  always @(posedge ACLK) begin
    if (!ARESET) begin
      if (p_awv && !p_awr && (!m_awvalid || m_awaddr != p_awa)) stab_viol <= stab_viol + 1;
      if (p_wv && !p_wr && (!m_wvalid || m_wdata != p_wd))      stab_viol <= stab_viol + 1;
      if (p_arv && !p_arr && m_arvalid && m_araddr != p_ara)    stab_viol <= stab_viol + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
    p_awv <= m_awvalid; p_awr <= m_awready; p_awa <= m_awaddr;
    p_wv  <= m_wvalid;  p_wr  <= m_wready;  p_wd  <= m_wdata;
    p_arv <= m_arvalid; p_arr <= m_arready; p_ara <= m_araddr;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_knobs();
    aw_dly = 0; w_dly = 0;
    berr_en = 1'b0; rerr_en = 1'b0; ar_stuck_en = 1'b0;
    berr_addr = '0; rerr_addr = '0; ar_stuck_addr = '0;
    for (int i = 0; i < 16; i++) rmask[i] = '0;
  endtask

  task automatic run_sweep(input logic [31:0] s, output int unsigned cyc, output bit ok);
    seed = s; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; start = 1'b0; seed = '0;
    repeat (3) tick();
    ARESET = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_vec++; if (err_count !== 4'd0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    n_vec++; if (first_err_addr !== 32'h0) begin n_err++; $display("FAIL reset_first: got %h expected 0", first_err_addr); end
    n_vec++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got %b expected 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [0:3];
    int unsigned a0, w0, v0, cyc;
    bit ok;
    exp_d[0] = 32'h0101FFFF; exp_d[1] = 32'h0203FFFF;
    exp_d[2] = 32'h0407FFFE; exp_d[3] = 32'h080FFFFB;
    clear_knobs();
    a0 = aw_hs; w0 = w_hs; v0 = stab_viol;
    seed = 32'h0101FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    cyc = 0;
    while (!done && cyc < 2000) begin tick(); cyc++; end
    ok = done;
    n_vec++; if (!ok || cyc != 29) begin n_err++; $display("FAIL basic_latency: got %0d expected 29", cyc); end
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL basic_pass: got %b expected 1", pass); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    n_vec++; if (err_count !== 4'd0) begin n_err++; $display("FAIL basic_err: got %0d expected 0", err_count); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem[i] !== exp_d[i]) begin n_err++; $display("FAIL basic_wdata[%0d]: got %h expected %h", i, mem[i], exp_d[i]); end
    end
    n_vec++; if (aw_hs - a0 != 4 || w_hs - w0 != 4) begin n_err++; $display("FAIL basic_hs_count: got %0d/%0d expected 4/4", aw_hs - a0, w_hs - w0); end
    n_vec++; if (stab_viol != v0) begin n_err++; $display("FAIL basic_stability: got %0d expected %0d", stab_viol, v0); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL basic_pass_held: got %b expected 1", pass); end
  endtask

  task automatic test_start_ignored();
    int unsigned cyc;
    clear_knobs();
    seed = 32'h80000001; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc == 10) begin seed = 32'hFFFFFFFF; start = 1'b1; end
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    n_vec++; if (cyc != 29) begin n_err++; $display("FAIL ignore_latency: got %0d expected 29", cyc); end
    n_vec++; if (mem[1] !== 32'h00000002) begin n_err++; $display("FAIL ignore_wdata1: got %h expected 00000002", mem[1]); end
    n_vec++; if (mem[3] !== 32'h0000000F) begin n_err++; $display("FAIL ignore_wdata3: got %h expected 0000000f", mem[3]); end
    n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL ignore_pass: got %b expected 1", pass); end
  endtask

  task automatic test_mismatch();
    int unsigned cyc;
    bit ok;
    clear_knobs();
    rmask[2] = 32'h1;
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (!ok || cyc != 29) begin n_err++; $display("FAIL mism_latency: got %0d expected 29", cyc); end
    n_vec++; if (err_count !== 4'd1) begin n_err++; $display("FAIL mism_err: got %0d expected 1", err_count); end
    n_vec++; if (first_err_addr !== 32'h8) begin n_err++; $display("FAIL mism_first: got %h expected 8", first_err_addr); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL mism_pass: got %b expected 0", pass); end
  endtask

  task automatic test_resp_err();
    int unsigned cyc;
    bit ok;
    clear_knobs();
    berr_en = 1'b1; berr_addr = 32'h4;
    rmask[3] = 32'h10;
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL resp_done: got 0 expected 1"); end
    n_vec++; if (err_count !== 4'd2) begin n_err++; $display("FAIL resp_err: got %0d expected 2", err_count); end
    n_vec++; if (first_err_addr !== 32'h4) begin n_err++; $display("FAIL resp_first: got %h expected 4", first_err_addr); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL resp_pass: got %b expected 0", pass); end
  endtask

  task automatic test_multi_err();
    int unsigned cyc;
    bit ok;
    clear_knobs();
    berr_en = 1'b1; berr_addr = 32'h8;
    rmask[2] = 32'h80000000;
    rerr_en = 1'b1; rerr_addr = 32'hC;
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL multi_done: got 0 expected 1"); end
    n_vec++; if (err_count !== 4'd3) begin n_err++; $display("FAIL multi_err: got %0d expected 3", err_count); end
    n_vec++; if (first_err_addr !== 32'h8) begin n_err++; $display("FAIL multi_first: got %h expected 8", first_err_addr); end
  endtask

  task automatic test_ready_skew();
    int unsigned a0, w0, v0, cyc;
    bit ok;
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      clear_knobs();
      if (pass_i == 0) w_dly = 3; else aw_dly = 3;
      a0 = aw_hs; w0 = w_hs; v0 = stab_viol;
      run_sweep(32'h0101FFFF, cyc, ok);
      n_vec++; if (!ok || cyc != 41) begin n_err++; $display("FAIL skew%0d_latency: got %0d expected 41", pass_i, cyc); end
      n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL skew%0d_pass: got %b expected 1", pass_i, pass); end
      n_vec++; if (aw_hs - a0 != 4 || w_hs - w0 != 4) begin n_err++; $display("FAIL skew%0d_hs_count: got %0d/%0d expected 4/4", pass_i, aw_hs - a0, w_hs - w0); end
      n_vec++; if (stab_viol != v0) begin n_err++; $display("FAIL skew%0d_stability: got %0d expected %0d", pass_i, stab_viol, v0); end
      n_vec++; if (mem[3] !== 32'h080FFFFB) begin n_err++; $display("FAIL skew%0d_wdata3: got %h expected 080ffffb", pass_i, mem[3]); end
    end
    clear_knobs();
  endtask

`ifdef AXI_SELFTEST_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned cyc;
    bit ok;
    clear_knobs();
    ar_stuck_en = 1'b1; ar_stuck_addr = 32'h8;
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (!ok || cyc != 34) begin n_err++; $display("FAIL tmo_latency: got %0d expected 34", cyc); end
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b expected 1", timeout); end
    n_vec++; if (err_count !== 4'd1) begin n_err++; $display("FAIL tmo_err: got %0d expected 1", err_count); end
    n_vec++; if (first_err_addr !== 32'h8) begin n_err++; $display("FAIL tmo_first: got %h expected 8", first_err_addr); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL tmo_pass: got %b expected 0", pass); end
    n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL tmo_arvalid_drop: got %b expected 0", m_arvalid); end
    clear_knobs();
  endtask
`else
  task automatic test_timeout();
    int unsigned cyc;
    bit ok;
    clear_knobs();
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_tied: got %b expected 0", timeout); end
  endtask
`endif

  task automatic test_reset_mid();
    int unsigned n, d0, cyc;
    bit ok;
    clear_knobs();
    seed = 32'h0101FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_bready && last_waddr == 32'h4) && n < 200) begin tick(); n++; end
    n_vec++; if (n >= 200) begin n_err++; $display("FAIL rstmid_reach_wb1: got timeout expected reg1 WB"); end
    d0 = done_cnt;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    n_vec++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_err++;
      $display("FAIL rstmid_handshake: got %b expected 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    n_vec++; if (busy !== 1'b0 || pass !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_pass: got %b%b expected 00", busy, pass); end
    n_vec++; if (err_count !== 4'd0 || first_err_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_err: got %0d/%h expected 0/0", err_count, first_err_addr); end
    repeat (40) tick();
    n_vec++; if (done_cnt != d0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - d0); end
    run_sweep(32'h0101FFFF, cyc, ok);
    n_vec++; if (!ok || cyc != 29) begin n_err++; $display("FAIL rstmid_restart_latency: got %0d expected 29", cyc); end
    n_vec++; if (pass !== 1'b1 || err_count !== 4'd0) begin n_err++; $display("FAIL rstmid_restart_pass: got %b/%0d expected 1/0", pass, err_count); end
  endtask

  initial begin
    clear_knobs();
    ARESET = 1'b1; start = 1'b0; seed = '0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_mismatch();
    test_resp_err();
    test_multi_err();
    test_ready_skew();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
